// File: rtl/lcd_timing_regs.sv
// lcd_timing_regs: LCD timing and status register block on the CPU external bus.
// Holds LCDC/STAT/SCY/SCX/LYC/WY/WX, runs the dot/line counters and the STAT
// mode sequence, and raises one-cycle VBlank and STAT interrupt pulses.
//
// Ports:
//   clock, reset       one dot per clock; reset is asynchronous, active-high
//   addr, data_in      CPU bus address and write data
//   mem_we, mem_re     CPU write / read strobes
//   data_out           read data for the FF40-FF4B map (8'hFF when not decoded)
//   data_out_en        bus tristate enable: read strobe, no write, address hit
//   vblank_irq         one-cycle pulse on the LY 143->144 transition
//   stat_irq           one-cycle pulse on each rising edge of the STAT line
//   ly, mode           current line and current STAT mode
module lcd_timing_regs #(
    parameter int unsigned DOTS_PER_LINE   = 456,
    parameter int unsigned LINES_PER_FRAME = 154,
    parameter int unsigned VISIBLE_LINES   = 144,
    parameter int unsigned OAM_DOTS        = 80,
    parameter int unsigned XFER_DOTS       = 172
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [7:0]  data_out,
    output logic        data_out_en,
    output logic        vblank_irq,
    output logic        stat_irq,
    output logic [7:0]  ly,
    output logic [1:0]  mode
);

    localparam int unsigned DOT_W = 9;
    localparam int unsigned LY_W  = 8;

    localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] DOT_XFER  = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] DOT_HBL   = DOT_W'(OAM_DOTS + XFER_DOTS);
    localparam logic [LY_W-1:0]  LY_LAST   = LY_W'(LINES_PER_FRAME - 1);
    localparam logic [LY_W-1:0]  LY_VBLANK = LY_W'(VISIBLE_LINES);
    localparam logic [LY_W-1:0]  LY_PREVB  = LY_W'(VISIBLE_LINES - 1);

    localparam logic [3:0] OFS_LCDC = 4'h0;
    localparam logic [3:0] OFS_STAT = 4'h1;
    localparam logic [3:0] OFS_SCY  = 4'h2;
    localparam logic [3:0] OFS_SCX  = 4'h3;
    localparam logic [3:0] OFS_LY   = 4'h4;
    localparam logic [3:0] OFS_LYC  = 4'h5;
    localparam logic [3:0] OFS_WY   = 4'hA;
    localparam logic [3:0] OFS_WX   = 4'hB;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_t;

    // Register state
    logic [7:0]       lcdc_q, scy_q, scx_q, lyc_q, wy_q, wx_q;
    logic [3:0]       stat_en_q;
    logic [DOT_W-1:0] dot_q;
    logic [LY_W-1:0]  ly_q;
    mode_t            mode_q;
    logic             coinc_q, line_q, vblank_q, stat_irq_q;

    // Next-state values
    logic [DOT_W-1:0] dot_n;
    logic [LY_W-1:0]  ly_n;
    mode_t            mode_n;
    logic [3:0]       stat_en_n;
    logic             en_next, coinc_n, line_n, vblank_n, stat_irq_n;

    // Bus decode
    logic       hit;
    logic [7:0] rd_data;
    logic       wr, wr_lcdc, wr_stat, wr_ly;

    // Mode for a given line/dot position while the LCD is running
    function automatic mode_t mode_for(input logic [LY_W-1:0] l, input logic [DOT_W-1:0] d);
        mode_t m;
        if (l >= LY_VBLANK)    m = MODE_VBLANK;
        else if (d < DOT_XFER) m = MODE_OAM;
        else if (d < DOT_HBL)  m = MODE_XFER;
        else                   m = MODE_HBLANK;
        return m;
    endfunction

    // Address decode and combinational read mux
    always_comb begin
        hit     = 1'b0;
        rd_data = 8'hFF;
        if (addr[15:4] == 12'hFF4) begin
            case (addr[3:0])
                OFS_LCDC: begin hit = 1'b1; rd_data = lcdc_q; end
                OFS_STAT: begin hit = 1'b1; rd_data = {1'b1, stat_en_q, coinc_q, 2'(mode_q)}; end
                OFS_SCY:  begin hit = 1'b1; rd_data = scy_q; end
                OFS_SCX:  begin hit = 1'b1; rd_data = scx_q; end
                OFS_LY:   begin hit = 1'b1; rd_data = ly_q; end
                OFS_LYC:  begin hit = 1'b1; rd_data = lyc_q; end
                OFS_WY:   begin hit = 1'b1; rd_data = wy_q; end
                OFS_WX:   begin hit = 1'b1; rd_data = wx_q; end
                default:  ;
            endcase
        end
    end

    assign wr      = mem_we & hit;
    assign wr_lcdc = wr & (addr[3:0] == OFS_LCDC);
    assign wr_stat = wr & (addr[3:0] == OFS_STAT);
    assign wr_ly   = wr & (addr[3:0] == OFS_LY);

    assign data_out    = rd_data;
    assign data_out_en = mem_re & ~mem_we & hit;
    assign vblank_irq  = vblank_q;
    assign stat_irq    = stat_irq_q;
    assign ly          = ly_q;
    assign mode        = 2'(mode_q);

    // Counters, mode sequence and interrupt next-state
    always_comb begin
        dot_n      = dot_q;
        ly_n       = ly_q;
        mode_n     = mode_q;
        en_next    = lcdc_q[7];
        stat_en_n  = stat_en_q;
        coinc_n    = 1'b0;
        line_n     = 1'b0;
        vblank_n   = 1'b0;
        stat_irq_n = 1'b0;

        // A same-edge LCDC write decides the enable seen by this edge
        if (wr_lcdc) en_next = data_in[7];

        if (!en_next) begin
            dot_n  = '0;
            ly_n   = '0;
            mode_n = MODE_HBLANK;
        end else if (!lcdc_q[7] || wr_ly) begin
            // Re-enable or an LY write restarts the frame; the clear beats a wrap
            dot_n  = '0;
            ly_n   = '0;
            mode_n = MODE_OAM;
        end else begin
            if (dot_q == DOT_LAST) begin
                dot_n = '0;
                ly_n  = (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
            end else begin
                dot_n = dot_q + 9'd1;
            end
            mode_n = mode_for(ly_n, dot_n);
        end

        if (wr_stat) stat_en_n = data_in[6:3];

        // Compare uses current LY/LYC, so STAT[2] trails an LY change by a cycle
        coinc_n = (ly_q == lyc_q);

        line_n = (stat_en_n[3] & coinc_n)
               | (stat_en_n[2] & (mode_n == MODE_OAM))
               | (stat_en_n[1] & (mode_n == MODE_VBLANK))
               | (stat_en_n[0] & (mode_n == MODE_HBLANK));

        vblank_n   = en_next & (ly_q == LY_PREVB) & (ly_n == LY_VBLANK);
        stat_irq_n = en_next & line_n & ~line_q;
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lcdc_q     <= 8'h91;
            stat_en_q  <= 4'h0;
            scy_q      <= 8'h00;
            scx_q      <= 8'h00;
            lyc_q      <= 8'h00;
            wy_q       <= 8'h00;
            wx_q       <= 8'h00;
            dot_q      <= '0;
            ly_q       <= '0;
            mode_q     <= MODE_OAM;
            coinc_q    <= 1'b0;
            line_q     <= 1'b0;
            vblank_q   <= 1'b0;
            stat_irq_q <= 1'b0;
        end else begin
            if (wr_lcdc) lcdc_q <= data_in;
            if (wr && addr[3:0] == OFS_SCY) scy_q <= data_in;
            if (wr && addr[3:0] == OFS_SCX) scx_q <= data_in;
            if (wr && addr[3:0] == OFS_LYC) lyc_q <= data_in;
            if (wr && addr[3:0] == OFS_WY)  wy_q  <= data_in;
            if (wr && addr[3:0] == OFS_WX)  wx_q  <= data_in;
            stat_en_q  <= stat_en_n;
            dot_q      <= dot_n;
            ly_q       <= ly_n;
            mode_q     <= mode_n;
            coinc_q    <= coinc_n;
            line_q     <= line_n;
            vblank_q   <= vblank_n;
            stat_irq_q <= stat_irq_n;
        end
    end

endmodule
